// File: rtl/key_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// key_conditioner_pkg
//   Shared definitions for the pushbutton conditioner: the per-channel
//   debounce state encoding and a helper that sizes the channel counters.
// ---------------------------------------------------------------------------
package key_conditioner_pkg;

    // Per-channel debounce states (encoding fixed so it matches board docs).
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } key_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Counter width: one bit more than needed for the largest constant, so
    // the repeat window end (REPEAT_DELAY+REPEAT_PERIOD-1) always fits.
    function automatic int cnt_width(input int stable, input int delay, input int period);
        return $clog2(max3(stable, delay, period)) + 1;
    endfunction

endpackage

// File: rtl/key_conditioner_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
//   One pushbutton channel: 2-flop synchronizer, debounce FSM, debounced
//   level and registered 1-cycle press / release / auto-repeat pulses.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   key_l_i    raw button, active low, asynchronous and bouncing
//   level_o    debounced pressed level (active high)
//   press_o    1-cycle pulse on accepted press
//   release_o  1-cycle pulse on accepted release
//   repeat_o   1-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module key_debounce_ch
    import key_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_l_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int CW = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_FIRST   = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_WRAP    = CW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam bit REPEAT_EN  = (REPEAT_DELAY > 0);
    localparam bit STABLE_ONE = (STABLE_CYCLES == 1);

    logic          sync1_q, sync2_q;
    logic          pressed_s;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;

    // Two-stage synchronizer on the raw (active-low) key; reset = released.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_l_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ~sync2_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            rcnt_q    <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    if (STABLE_ONE) begin
                        state_d = HELD;
                        cnt_d   = CNT_ZERO;
                        rcnt_d  = CNT_ZERO;
                    end else begin
                        state_d = DEB_PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            DEB_PRESS: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                    rcnt_d  = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    state_d = STABLE_ONE ? IDLE : DEB_RELEASE;
                    cnt_d   = STABLE_ONE ? CNT_ZERO : CNT_ONE;
                end else if (REPEAT_EN) begin
                    // Past the first repeat the counter cycles inside
                    // [REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD-1], so it
                    // never overflows however long the key is held.
                    rcnt_d = (rcnt_q == RPT_WRAP) ? RPT_FIRST : (rcnt_q + CNT_ONE);
                end else begin
                    rcnt_d = rcnt_q;
                end
            end
            DEB_RELEASE: begin
                // rcnt is frozen here; a glitch back to HELD resumes it.
                if (pressed_s) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                rcnt_d  = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the transition; registered in the state block.
    always_comb begin
        level_d   = (state_d == HELD) || (state_d == DEB_RELEASE);
        press_d   = (state_d == HELD) && ((state_q == DEB_PRESS) || (state_q == IDLE));
        release_d = (state_d == IDLE) && ((state_q == DEB_RELEASE) || (state_q == HELD));
        repeat_d  = REPEAT_EN && (state_q == HELD) && (state_d == HELD) && (rcnt_d == RPT_FIRST);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//   Conditions the active-low board pushbuttons: N_KEYS independent
//   debounce channels, all in the CLK domain.
// Ports:
//   CLK      system clock
//   RESET    synchronous active-high reset
//   KEY_L    raw pushbuttons, active low, asynchronous, bouncing
//   LEVEL    debounced pressed level, active high
//   PRESS    1-cycle pulse per accepted press
//   RELEASE  1-cycle pulse per accepted release
//   REPEAT   1-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int STABLE_CYCLES = 1000,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY_L,
    output logic [N_KEYS-1:0] LEVEL,
    output logic [N_KEYS-1:0] PRESS,
    output logic [N_KEYS-1:0] RELEASE,
    output logic [N_KEYS-1:0] REPEAT
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RESET),
            .key_l_i   (KEY_L[g]),
            .level_o   (LEVEL[g]),
            .press_o   (PRESS[g]),
            .release_o (RELEASE[g]),
            .repeat_o  (REPEAT[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int S = 4;
    localparam int D = 10;
    localparam int P = 3;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] KEY_L;
    logic [3:0] LEVEL, PRESS, RELEASE, REPEAT;
    logic [3:0] LEVEL0, PRESS0, RELEASE0, REPEAT0;

    key_conditioner #(.N_KEYS(4), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .CLK(CLK), .RESET(RESET), .KEY_L(KEY_L),
        .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE), .REPEAT(REPEAT));

    key_conditioner #(.N_KEYS(4), .STABLE_CYCLES(S), .REPEAT_DELAY(0), .REPEAT_PERIOD(P)) dut0 (
        .CLK(CLK), .RESET(RESET), .KEY_L(KEY_L),
        .LEVEL(LEVEL0), .PRESS(PRESS0), .RELEASE(RELEASE0), .REPEAT(REPEAT0));

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model (one per instance) ----------------
    // A key's accepted level flips after S consecutive synced samples that
    // disagree with it. Held steps count consecutive pressed samples while
    // settled pressed; repeats fire at step D, D+P, D+2P, ...
    logic [15:0] exp_q [2][$];
    bit raw1 [2][4];
    bit raw2 [2][4];
    bit lvl  [2][4];
    int run  [2][4];
    int hold [2][4];

    always @(posedge CLK) begin
        for (int m = 0; m < 2; m++) begin
            logic [3:0] lv, pr, rl, rp;
            int dly;
            bit s, step;
            dly = (m == 0) ? D : 0;
            lv = 4'd0; pr = 4'd0; rl = 4'd0; rp = 4'd0;
            for (int i = 0; i < 4; i++) begin
                if (RESET) begin
                    raw1[m][i] = 1'b1; raw2[m][i] = 1'b1;
                    lvl[m][i] = 1'b0; run[m][i] = 0; hold[m][i] = 0;
                end else begin
                    s = ~raw2[m][i];
                    raw2[m][i] = raw1[m][i];
                    raw1[m][i] = KEY_L[i];
                    step = lvl[m][i] && (run[m][i] == 0) && s;
                    if (s != lvl[m][i]) run[m][i]++;
                    else run[m][i] = 0;
                    if (run[m][i] >= S) begin
                        lvl[m][i] = ~lvl[m][i];
                        run[m][i] = 0;
                        if (lvl[m][i]) begin pr[i] = 1'b1; hold[m][i] = 0; end
                        else rl[i] = 1'b1;
                    end
                    if (step) begin
                        hold[m][i]++;
                        if (dly > 0 && hold[m][i] >= dly && ((hold[m][i] - dly) % P) == 0)
                            rp[i] = 1'b1;
                    end
                end
                lv[i] = lvl[m][i];
            end
            exp_q[m].push_back({lv, pr, rl, rp});
        end
    end

    // ---------------- monitor ----------------
    logic [15:0] e;
    int press_cnt [4];
    int rel_cnt   [4];

    initial for (int i = 0; i < 4; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end

    always @(negedge CLK) begin
        if (exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front();
            check("outputs_rpt", {LEVEL, PRESS, RELEASE, REPEAT}, e);
        end
        if (exp_q[1].size() > 0) begin
            e = exp_q[1].pop_front();
            check("outputs_norpt", {LEVEL0, PRESS0, RELEASE0, REPEAT0}, e);
        end
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] += int'(PRESS[i]);
            rel_cnt[i]   += int'(RELEASE[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] keys, input logic rst);
        @(negedge CLK);
        KEY_L = keys;
        RESET = rst;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Counts cycles from the last drive until all masked bits pulse.
    task automatic wait_evt(input bit rel, input logic [3:0] mask, input int exp_cyc, input string name);
        int k;
        bit hit;
        k = 0; hit = 1'b0;
        while (!hit && k < 40) begin
            @(posedge CLK); #1;
            k++;
            if ((((rel) ? RELEASE : PRESS) & mask) == mask) hit = 1'b1;
        end
        check(name, 16'(k), 16'(exp_cyc));
        @(posedge CLK); #1;
        check({name, "_width"}, 16'(((rel) ? RELEASE : PRESS) & mask), 16'd0);
    endtask

    int p_snap, r_snap, rep, rep0;
    logic [3:0] keys;
    int rate;

    initial begin
        RESET = 1'b1;
        KEY_L = 4'hF;
        idle(3);

        // 1: reset with all keys pressed, then all accepted together
        drive(4'h0, 1'b1);
        drive(4'h0, 1'b1);
        drive(4'h0, 1'b0);
        wait_evt(1'b0, 4'hF, 6, "t1_press_all");
        drive(4'hF, 1'b0);
        wait_evt(1'b1, 4'hF, 6, "t1_release_all");
        idle(5);

        // 2: clean press on key 0
        drive(4'hE, 1'b0);
        wait_evt(1'b0, 4'h1, 6, "t2_press0");
        idle(5);

        // 4: 2-cycle release glitch on key 0, then a true release
        p_snap = press_cnt[0]; r_snap = rel_cnt[0];
        drive(4'hF, 1'b0);
        drive(4'hF, 1'b0);
        drive(4'hE, 1'b0);
        idle(10);
        check("t4_no_release", 16'(rel_cnt[0] - r_snap), 16'd0);
        check("t4_no_repress", 16'(press_cnt[0] - p_snap), 16'd0);
        check("t4_level", 16'(LEVEL[0]), 16'd1);
        drive(4'hF, 1'b0);
        wait_evt(1'b1, 4'h1, 6, "t4_release0");
        idle(5);

        // 3: key 1 bounces every 2 cycles, never accepted
        p_snap = press_cnt[1]; r_snap = rel_cnt[1];
        for (int j = 0; j < 5; j++) begin
            drive(4'hD, 1'b0); drive(4'hD, 1'b0);
            drive(4'hF, 1'b0); drive(4'hF, 1'b0);
        end
        idle(10);
        check("t3_no_press", 16'(press_cnt[1] - p_snap), 16'd0);
        check("t3_no_release", 16'(rel_cnt[1] - r_snap), 16'd0);
        check("t3_level", 16'(LEVEL[1]), 16'd0);

        // 5: key 3 held 30 cycles after PRESS: repeats at 10,13,...,28
        drive(4'h7, 1'b0);
        wait_evt(1'b0, 4'h8, 6, "t5_press3");
        rep = 0; rep0 = 0;
        repeat (29) begin
            @(posedge CLK); #1;
            rep  += int'(REPEAT[3]);
            rep0 += int'(REPEAT0[3]);
        end
        check("t5_repeat_count", 16'(rep), 16'd7);
        check("t5_repeat_disabled", 16'(rep0), 16'd0);
        drive(4'hF, 1'b0);
        wait_evt(1'b1, 4'h8, 6, "t5_release3");
        idle(5);

        // 6: reset while key 2 held
        drive(4'hB, 1'b0);
        wait_evt(1'b0, 4'h4, 6, "t6_press2");
        idle(4);
        r_snap = rel_cnt[2];
        drive(4'hB, 1'b1);
        @(posedge CLK); #1;
        check("t6_level_cleared", 16'(LEVEL[2]), 16'd0);
        drive(4'hB, 1'b0);
        wait_evt(1'b0, 4'h4, 6, "t6_repress2");
        check("t6_no_release", 16'(rel_cnt[2] - r_snap), 16'd0);
        drive(4'hF, 1'b0);
        idle(12);

        // randomized phases with varying bounce rates and rare resets
        for (int ph = 0; ph < 12; ph++) begin
            rate = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 6 : 25);
            for (int c = 0; c < 250; c++) begin
                keys = KEY_L;
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(rate - 1, 0) == 0) keys[i] = ~keys[i];
                drive(keys, ($urandom_range(299, 0) == 0) ? 1'b1 : 1'b0);
            end
        end
        drive(4'hF, 1'b0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
